// File: rtl/trap_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// trap_ctrl_pkg
// Shared definitions for the machine-mode trap controller:
//   - CSR addresses written during trap entry / return
//   - exception and interrupt cause codes (the interrupt flag is the MSB)
//   - mstatus / mie bit positions
//   - trap sequencer state encoding
// ---------------------------------------------------------------------------
package trap_ctrl_pkg;

    // CSR addresses
    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    // mstatus bit positions
    localparam int unsigned MSTATUS_MIE    = 3;
    localparam int unsigned MSTATUS_MPIE   = 7;
    localparam int unsigned MSTATUS_MPP_LO = 11;
    localparam int unsigned MSTATUS_MPP_HI = 12;

    // mie bit positions
    localparam int unsigned MIE_MSIE = 3;
    localparam int unsigned MIE_MTIE = 7;
    localparam int unsigned MIE_MEIE = 11;

    // mcause exception codes (interrupt flag clear)
    localparam logic [4:0] EXC_ILLEGAL    = 5'd2;
    localparam logic [4:0] EXC_BREAKPOINT = 5'd3;
    localparam logic [4:0] EXC_ECALL_M    = 5'd11;

    // mcause interrupt codes (interrupt flag set in the MSB of mcause)
    localparam logic [4:0] IRQ_M_SOFT  = 5'd3;
    localparam logic [4:0] IRQ_M_TIMER = 5'd7;
    localparam logic [4:0] IRQ_M_EXT   = 5'd11;

    // Trap sequencer states
    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WR_MSTATUS = 3'd1,
        ST_WR_MEPC    = 3'd2,
        ST_WR_MCAUSE  = 3'd3,
        ST_MRET_WR    = 3'd4,
        ST_ASSERT     = 3'd5
    } trap_state_e;

endpackage

// File: rtl/trap_prio_enc.sv
// ---------------------------------------------------------------------------
// trap_prio_enc
// Combinational priority encoder for trap requests seen in IDLE.
// Priority (highest first): illegal, ebreak, ecall, mret, external irq,
// software irq, timer irq. An interrupt only counts when its mie bit and the
// global mstatus.MIE bit are both set.
// Ports:
//   ecall_i/ebreak_i/illegal_i  decode-stage exception pulses
//   mret_i                      decode-stage mret
//   irq_ext_i/irq_tmr_i/irq_sw_i level interrupt requests
//   mie_i, mstatus_i            current CSR values
//   valid_o                     some request is present
//   cause_o                     mcause value for the winning trap
//   is_irq_o                    winner is an interrupt
//   is_mret_o                   winner is mret (cause_o is 0)
// ---------------------------------------------------------------------------
module trap_prio_enc
    import trap_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  ecall_i,
    input  logic                  ebreak_i,
    input  logic                  illegal_i,
    input  logic                  mret_i,
    input  logic                  irq_ext_i,
    input  logic                  irq_tmr_i,
    input  logic                  irq_sw_i,
    input  logic [DATA_WIDTH-1:0] mie_i,
    input  logic [DATA_WIDTH-1:0] mstatus_i,
    output logic                  valid_o,
    output logic [DATA_WIDTH-1:0] cause_o,
    output logic                  is_irq_o,
    output logic                  is_mret_o
);

    logic       gie;
    logic       ext_en;
    logic       tmr_en;
    logic       sw_en;
    logic [4:0] code;
    logic       unused_status_bits;

    assign gie    = mstatus_i[MSTATUS_MIE];
    assign ext_en = irq_ext_i & mie_i[MIE_MEIE] & gie;
    assign tmr_en = irq_tmr_i & mie_i[MIE_MTIE] & gie;
    assign sw_en  = irq_sw_i  & mie_i[MIE_MSIE] & gie;

    // Only a few enable bits matter here.
    assign unused_status_bits = ^{mie_i, mstatus_i};

    always_comb begin
        valid_o   = 1'b0;
        is_irq_o  = 1'b0;
        is_mret_o = 1'b0;
        code      = 5'd0;
        if (illegal_i) begin
            valid_o = 1'b1;
            code    = EXC_ILLEGAL;
        end else if (ebreak_i) begin
            valid_o = 1'b1;
            code    = EXC_BREAKPOINT;
        end else if (ecall_i) begin
            valid_o = 1'b1;
            code    = EXC_ECALL_M;
        end else if (mret_i) begin
            valid_o   = 1'b1;
            is_mret_o = 1'b1;
        end else if (ext_en) begin
            valid_o  = 1'b1;
            is_irq_o = 1'b1;
            code     = IRQ_M_EXT;
        end else if (sw_en) begin
            valid_o  = 1'b1;
            is_irq_o = 1'b1;
            code     = IRQ_M_SOFT;
        end else if (tmr_en) begin
            valid_o  = 1'b1;
            is_irq_o = 1'b1;
            code     = IRQ_M_TIMER;
        end
        cause_o = {is_irq_o, {(DATA_WIDTH-6){1'b0}}, code};
    end

endmodule

// File: rtl/trap_ctrl.sv
// ---------------------------------------------------------------------------
// trap_ctrl
// Machine-mode trap/interrupt controller. Sequences trap entry
// (mstatus, mepc, mcause writes then a fetch redirect to mtvec) and mret
// (mstatus write then a redirect to mepc) through one CSR write port.
// Ports:
//   clk_i, rst_i         clock, asynchronous active-low reset
//   inst_addr_i          PC of the instruction in decode
//   ecall_i/ebreak_i/illegal_i/mret_i  decode-stage requests (pulses)
//   irq_ext_i/irq_tmr_i/irq_sw_i       level interrupt requests
//   mtvec_i/mepc_i/mstatus_i/mie_i     current CSR values
//   csr_we_o/csr_waddr_o/csr_wdata_o   CSR write port (addr/data 0 when idle)
//   hold_o               stall fetch/decode, block writeback CSR writes
//   int_assert_o         one-cycle redirect strobe
//   int_addr_o           redirect target
//   dbg_state_o          current sequencer state
// All outputs except hold_o are registered.
// ---------------------------------------------------------------------------
module trap_ctrl
    import trap_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned CSR_ADDR_WIDTH = 12,
    parameter bit          VECTORED_EN    = 1'b1
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [ADDR_WIDTH-1:0]     inst_addr_i,
    input  logic                      ecall_i,
    input  logic                      ebreak_i,
    input  logic                      illegal_i,
    input  logic                      mret_i,
    input  logic                      irq_ext_i,
    input  logic                      irq_tmr_i,
    input  logic                      irq_sw_i,
    input  logic [DATA_WIDTH-1:0]     mtvec_i,
    input  logic [DATA_WIDTH-1:0]     mepc_i,
    input  logic [DATA_WIDTH-1:0]     mstatus_i,
    input  logic [DATA_WIDTH-1:0]     mie_i,
    output logic                      csr_we_o,
    output logic [CSR_ADDR_WIDTH-1:0] csr_waddr_o,
    output logic [DATA_WIDTH-1:0]     csr_wdata_o,
    output logic                      hold_o,
    output logic                      int_assert_o,
    output logic [ADDR_WIDTH-1:0]     int_addr_o,
    output trap_state_e               dbg_state_o
);

    trap_state_e               state_q;
    logic [DATA_WIDTH-1:0]     cause_q;
    logic [ADDR_WIDTH-1:0]     pc_q;
    logic                      irq_q;
    logic                      csr_we_q;
    logic [CSR_ADDR_WIDTH-1:0] csr_waddr_q;
    logic [DATA_WIDTH-1:0]     csr_wdata_q;
    logic                      int_assert_q;
    logic [ADDR_WIDTH-1:0]     int_addr_q;

    logic                      req_valid;
    logic [DATA_WIDTH-1:0]     req_cause;
    logic                      req_is_irq;
    logic                      req_is_mret;

    logic [DATA_WIDTH-1:0]     mstatus_trap_d;
    logic [DATA_WIDTH-1:0]     mstatus_mret_d;
    logic [ADDR_WIDTH-1:0]     trap_target_d;
    logic [ADDR_WIDTH-1:0]     mret_target_d;
    logic                      unused_mepc_bits;

    trap_prio_enc #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_prio_enc (
        .ecall_i    (ecall_i),
        .ebreak_i   (ebreak_i),
        .illegal_i  (illegal_i),
        .mret_i     (mret_i),
        .irq_ext_i  (irq_ext_i),
        .irq_tmr_i  (irq_tmr_i),
        .irq_sw_i   (irq_sw_i),
        .mie_i      (mie_i),
        .mstatus_i  (mstatus_i),
        .valid_o    (req_valid),
        .cause_o    (req_cause),
        .is_irq_o   (req_is_irq),
        .is_mret_o  (req_is_mret)
    );

    // mstatus images: the first write of a sequence is prepared from the
    // live CSR value in the detect cycle so it can leave a register at T1.
    always_comb begin
        mstatus_trap_d = mstatus_i;
        mstatus_trap_d[MSTATUS_MPIE] = mstatus_i[MSTATUS_MIE];
        mstatus_trap_d[MSTATUS_MIE]  = 1'b0;
        mstatus_trap_d[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;

        mstatus_mret_d = mstatus_i;
        mstatus_mret_d[MSTATUS_MIE]  = mstatus_i[MSTATUS_MPIE];
        mstatus_mret_d[MSTATUS_MPIE] = 1'b1;
        mstatus_mret_d[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b00;
    end

    // Vectored mode only applies to interrupts; exceptions always go to base.
    always_comb begin
        trap_target_d = {mtvec_i[ADDR_WIDTH-1:2], 2'b00};
        if (VECTORED_EN && irq_q && (mtvec_i[1:0] == 2'b01)) begin
            trap_target_d = trap_target_d
                          + ADDR_WIDTH'({cause_q[DATA_WIDTH-2:0], 2'b00});
        end
    end

    assign mret_target_d    = {mepc_i[ADDR_WIDTH-1:2], 2'b00};
    assign unused_mepc_bits = ^mepc_i[1:0];

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q      <= ST_IDLE;
            cause_q      <= '0;
            pc_q         <= '0;
            irq_q        <= 1'b0;
            csr_we_q     <= 1'b0;
            csr_waddr_q  <= '0;
            csr_wdata_q  <= '0;
            int_assert_q <= 1'b0;
            int_addr_q   <= '0;
        end else begin
            // Write port and redirect strobe are single-cycle by default.
            csr_we_q     <= 1'b0;
            csr_waddr_q  <= '0;
            csr_wdata_q  <= '0;
            int_assert_q <= 1'b0;
            int_addr_q   <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        csr_we_q    <= 1'b1;
                        csr_waddr_q <= CSR_ADDR_WIDTH'(CSR_MSTATUS);
                        if (req_is_mret) begin
                            state_q     <= ST_MRET_WR;
                            csr_wdata_q <= mstatus_mret_d;
                        end else begin
                            state_q     <= ST_WR_MSTATUS;
                            cause_q     <= req_cause;
                            pc_q        <= inst_addr_i;
                            irq_q       <= req_is_irq;
                            csr_wdata_q <= mstatus_trap_d;
                        end
                    end
                end
                ST_WR_MSTATUS: begin
                    state_q     <= ST_WR_MEPC;
                    csr_we_q    <= 1'b1;
                    csr_waddr_q <= CSR_ADDR_WIDTH'(CSR_MEPC);
                    csr_wdata_q <= DATA_WIDTH'(pc_q);
                end
                ST_WR_MEPC: begin
                    state_q     <= ST_WR_MCAUSE;
                    csr_we_q    <= 1'b1;
                    csr_waddr_q <= CSR_ADDR_WIDTH'(CSR_MCAUSE);
                    csr_wdata_q <= cause_q;
                end
                ST_WR_MCAUSE: begin
                    state_q      <= ST_ASSERT;
                    int_assert_q <= 1'b1;
                    int_addr_q   <= trap_target_d;
                end
                ST_MRET_WR: begin
                    state_q      <= ST_ASSERT;
                    int_assert_q <= 1'b1;
                    int_addr_q   <= mret_target_d;
                end
                ST_ASSERT: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Reset gating keeps hold_o low while reset is applied even if a
    // request is sitting on the inputs.
    assign hold_o       = rst_i & ((state_q != ST_IDLE) | req_valid);
    assign csr_we_o     = csr_we_q;
    assign csr_waddr_o  = csr_waddr_q;
    assign csr_wdata_o  = csr_wdata_q;
    assign int_assert_o = int_assert_q;
    assign int_addr_o   = int_addr_q;
    assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// ---------------------------------------------------------------------------
// tb_trap_ctrl
// Directed bench for trap_ctrl. Inputs change 1 ns after the rising edge,
// outputs are sampled on the falling edge. Expected CSR writes are queued
// and compared by a write monitor; cycle-level behaviour is checked inline.
// ---------------------------------------------------------------------------
module tb_trap_ctrl;
    import trap_ctrl_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_i = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic [31:0] inst_addr_i = '0;
    logic        ecall_i = 1'b0, ebreak_i = 1'b0, illegal_i = 1'b0, mret_i = 1'b0;
    logic        irq_ext_i = 1'b0, irq_tmr_i = 1'b0, irq_sw_i = 1'b0;
    logic [31:0] mtvec_i = '0, mepc_i = '0, mstatus_i = '0, mie_i = '0;
    logic        csr_we_o;
    logic [11:0] csr_waddr_o;
    logic [31:0] csr_wdata_o;
    logic        hold_o;
    logic        int_assert_o;
    logic [31:0] int_addr_o;
    trap_state_e dbg_state_o;

    trap_ctrl #(
        .ADDR_WIDTH     (32),
        .DATA_WIDTH     (32),
        .CSR_ADDR_WIDTH (12),
        .VECTORED_EN    (1'b1)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .inst_addr_i  (inst_addr_i),
        .ecall_i      (ecall_i),
        .ebreak_i     (ebreak_i),
        .illegal_i    (illegal_i),
        .mret_i       (mret_i),
        .irq_ext_i    (irq_ext_i),
        .irq_tmr_i    (irq_tmr_i),
        .irq_sw_i     (irq_sw_i),
        .mtvec_i      (mtvec_i),
        .mepc_i       (mepc_i),
        .mstatus_i    (mstatus_i),
        .mie_i        (mie_i),
        .csr_we_o     (csr_we_o),
        .csr_waddr_o  (csr_waddr_o),
        .csr_wdata_o  (csr_wdata_o),
        .hold_o       (hold_o),
        .int_assert_o (int_assert_o),
        .int_addr_o   (int_addr_o),
        .dbg_state_o  (dbg_state_o)
    );

    // ---------------- scoreboard ----------------
    int          n_checks = 0;
    int          n_fails  = 0;
    logic [43:0] exp_q[$];
    logic [43:0] mon_exp;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Every CSR write the DUT issues must match the next queued expectation.
    always @(negedge clk) begin
        if (rst_i && csr_we_o) begin
            if (exp_q.size() == 0) begin
                check("csr_write_unexpected", {1'b1, 19'h0, csr_waddr_o, csr_wdata_o}, 64'h0);
            end else begin
                mon_exp = exp_q.pop_front();
                check("csr_write", {20'h0, csr_waddr_o, csr_wdata_o}, {20'h0, mon_exp});
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic clear_pulses();
        ecall_i   = 1'b0;
        ebreak_i  = 1'b0;
        illegal_i = 1'b0;
        mret_i    = 1'b0;
    endtask

    // Starts in the detect cycle T0 (request already driven), ends at the
    // start of T5. The bench plays the CSR file by applying the mstatus write.
    task automatic entry_seq(input string tag, input logic [31:0] ms,
                             input logic [31:0] pc, input logic [31:0] cause,
                             input logic [31:0] addr);
        exp_q.push_back({CSR_MSTATUS, ms});
        exp_q.push_back({CSR_MEPC, pc});
        exp_q.push_back({CSR_MCAUSE, cause});
        sample();
        check({tag, "_t0_hold"}, hold_o, 1'b1);
        check({tag, "_t0_we"}, csr_we_o, 1'b0);
        tick();
        clear_pulses();
        sample();
        check({tag, "_t1_we"}, csr_we_o, 1'b1);
        check({tag, "_t1_state"}, dbg_state_o, ST_WR_MSTATUS);
        check({tag, "_t1_hold"}, hold_o, 1'b1);
        tick();
        mstatus_i = ms;
        sample();
        check({tag, "_t2_we"}, csr_we_o, 1'b1);
        tick();
        sample();
        check({tag, "_t3_we"}, csr_we_o, 1'b1);
        check({tag, "_t3_assert"}, int_assert_o, 1'b0);
        tick();
        sample();
        check({tag, "_t4_assert"}, int_assert_o, 1'b1);
        check({tag, "_t4_addr"}, int_addr_o, addr);
        check({tag, "_t4_we"}, csr_we_o, 1'b0);
        check({tag, "_t4_waddr"}, csr_waddr_o, 12'h0);
        check({tag, "_t4_wdata"}, csr_wdata_o, 32'h0);
        check({tag, "_t4_hold"}, hold_o, 1'b1);
        tick();
    endtask

    // Starts at the mret detect cycle T0, ends at the start of T3.
    task automatic mret_seq(input string tag, input logic [31:0] ms, input logic [31:0] addr);
        exp_q.push_back({CSR_MSTATUS, ms});
        sample();
        check({tag, "_t0_hold"}, hold_o, 1'b1);
        tick();
        clear_pulses();
        sample();
        check({tag, "_t1_we"}, csr_we_o, 1'b1);
        check({tag, "_t1_state"}, dbg_state_o, ST_MRET_WR);
        tick();
        mstatus_i = ms;
        sample();
        check({tag, "_t2_assert"}, int_assert_o, 1'b1);
        check({tag, "_t2_addr"}, int_addr_o, addr);
        check({tag, "_t2_we"}, csr_we_o, 1'b0);
        tick();
    endtask

    task automatic check_quiet(input string tag, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            sample();
            check({tag, "_hold"}, hold_o, 1'b0);
            check({tag, "_we"}, csr_we_o, 1'b0);
            check({tag, "_assert"}, int_assert_o, 1'b0);
            tick();
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_we"}, csr_we_o, 1'b0);
        check({tag, "_waddr"}, csr_waddr_o, 12'h0);
        check({tag, "_wdata"}, csr_wdata_o, 32'h0);
        check({tag, "_hold"}, hold_o, 1'b0);
        check({tag, "_assert"}, int_assert_o, 1'b0);
        check({tag, "_addr"}, int_addr_o, 32'h0);
        check({tag, "_state"}, dbg_state_o, ST_IDLE);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        // Reset state, with a request present to show hold_o stays low.
        ecall_i = 1'b1;
        tick();
        tick();
        sample();
        check_all_zero("reset");
        tick();
        clear_pulses();
        rst_i = 1'b1;
        tick();

        // ecall, direct mode
        mstatus_i   = 32'h8;
        mtvec_i     = 32'h200;
        inst_addr_i = 32'h100;
        ecall_i     = 1'b1;
        entry_seq("ecall", 32'h1880, 32'h100, 32'd11, 32'h200);
        sample();
        check("ecall_t5_hold", hold_o, 1'b0);
        check("ecall_t5_assert", int_assert_o, 1'b0);
        tick();

        // timer interrupt, vectored mode: 0x200 + 4*7
        mstatus_i   = 32'h8;
        mie_i       = 32'h80;
        mtvec_i     = 32'h201;
        inst_addr_i = 32'h40;
        irq_tmr_i   = 1'b1;
        entry_seq("tmr", 32'h1880, 32'h40, 32'h8000_0007, 32'h21C);
        irq_tmr_i = 1'b0;
        check_quiet("tmr_after", 1);

        // mret with a timer interrupt pending; the interrupt follows at T3
        mstatus_i   = 32'h1880;
        mepc_i      = 32'h104;
        inst_addr_i = 32'h104;
        mie_i       = 32'h80;
        irq_tmr_i   = 1'b1;
        mret_i      = 1'b1;
        mret_seq("mret", 32'h88, 32'h104);
        entry_seq("mret_tmr", 32'h1880, 32'h104, 32'h8000_0007, 32'h21C);
        irq_tmr_i = 1'b0;
        check_quiet("mret_after", 1);

        // external interrupt masked by mstatus.MIE, then taken once enabled
        mstatus_i   = 32'h0;
        mie_i       = 32'h800;
        mtvec_i     = 32'h200;
        inst_addr_i = 32'h80;
        irq_ext_i   = 1'b1;
        check_quiet("ext_masked", 3);
        mstatus_i = 32'h8;
        entry_seq("ext", 32'h1880, 32'h80, 32'h8000_000B, 32'h200);
        check_quiet("ext_after", 2);
        irq_ext_i = 1'b0;

        // illegal and external interrupt together: exception wins, vectored
        // mode ignored for exceptions, interrupt not retaken (MIE now 0)
        mstatus_i   = 32'h8;
        mie_i       = 32'h800;
        mtvec_i     = 32'h201;
        inst_addr_i = 32'h300;
        irq_ext_i   = 1'b1;
        illegal_i   = 1'b1;
        entry_seq("illegal", 32'h1880, 32'h300, 32'd2, 32'h200);
        check_quiet("illegal_after", 3);
        irq_ext_i = 1'b0;

        // reset during WR_MEPC abandons the sequence
        mstatus_i   = 32'h8;
        mtvec_i     = 32'h200;
        inst_addr_i = 32'h500;
        ecall_i     = 1'b1;
        exp_q.push_back({CSR_MSTATUS, 32'h1880});
        exp_q.push_back({CSR_MEPC, 32'h500});
        sample();
        check("rstmid_t0_hold", hold_o, 1'b1);
        tick();
        clear_pulses();
        tick();
        sample();
        check("rstmid_t2_state", dbg_state_o, ST_WR_MEPC);
        check("rstmid_t2_we", csr_we_o, 1'b1);
        #2;
        rst_i = 1'b0;
        #1;
        check_all_zero("rstmid_async");
        tick();
        sample();
        rst_i = 1'b1;
        tick();
        check_quiet("rstmid_after", 4);
        sample();
        check("rstmid_state_idle", dbg_state_o, ST_IDLE);

        check("csr_writes_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
